// File: rtl/hex_to_sevseg_mux_pkg.sv
// Shared seven-segment types, the hex pattern table and the nibble encoder function.
// Patterns are active-high here; hex_to_seg returns the active-low bus value.
package sevseg_pkg;

  typedef logic [6:0] seg_t;

  // Must stay the exact inverse of the peripheral's segment-to-hex decoder.
  localparam seg_t SEG_PATTERN [16] = '{
    7'b1110111, 7'b1000001, 7'b1101110, 7'b1101011,
    7'b1011001, 7'b0111011, 7'b0111111, 7'b1100001,
    7'b1111111, 7'b1111001, 7'b1111101, 7'b0011111,
    7'b0110110, 7'b1001111, 7'b0111110, 7'b0111100
  };

  function automatic seg_t hex_to_seg(input logic [3:0] nibble);
    return ~SEG_PATTERN[nibble];
  endfunction

endpackage

// File: rtl/hex_to_sevseg_mux_if.sv
// Bus-side write port and display pins of the multiplexed seven-segment driver.
// master = CPU peripheral side / board pins observer, slave = the driver.
interface hex_to_sevseg_mux_if #(
  parameter int NUM_DIGITS = 4
);
  import sevseg_pkg::*;

  logic                    wr_en;
  logic [4*NUM_DIGITS-1:0] wr_data;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic [NUM_DIGITS-1:0]   blank_mask;
  seg_t                    seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_tick;

  modport master (
    output wr_en, wr_data, dp_mask, blank_mask,
    input  seg, dp, an, frame_tick
  );

  modport slave (
    input  wr_en, wr_data, dp_mask, blank_mask,
    output seg, dp, an, frame_tick
  );

endinterface

// File: rtl/hex_to_sevseg.sv
// Combinational nibble to active-low seven-segment encoder.
module hex_to_sevseg
  import sevseg_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/hex_to_sevseg_mux.sv
// Double-buffered, time-multiplexed hex display driver; outputs registered, one cycle behind (cnt, idx).
// Optional leading-zero blanking when SEVSEG_LEADING_ZERO_BLANK_EN is defined.
module hex_to_sevseg_mux
  import sevseg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                clk,
  input  logic                rst_n,
  hex_to_sevseg_mux_if.slave  bus
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] data;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   blank;
  } frame_t;

  frame_t                pend_q;
  frame_t                disp_q;
  frame_t                wr_frame;
  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic                  swap;
  logic [NUM_DIGITS-1:0] dark;
  logic [3:0]            nib;
  seg_t                  enc_seg;
  seg_t                  seg_q;
  logic                  dp_q;
  logic [NUM_DIGITS-1:0] an_q;
  logic                  tick_q;

  assign wr_frame = '{data: bus.wr_data, dp: bus.dp_mask, blank: bus.blank_mask};
  assign swap     = (cnt == CNT_LAST) && (idx == IDX_LAST);
  assign nib      = disp_q.data[{idx, 2'b00} +: 4];

  hex_to_sevseg u_enc (
    .nibble (nib),
    .seg    (enc_seg)
  );

`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
  // Walk down from the most significant digit; digit 0 always stays eligible.
  always_comb begin
    logic leading;
    leading = 1'b1;
    dark    = disp_q.blank;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (leading && (disp_q.data[4*i +: 4] == 4'h0)) begin
        dark[i] = 1'b1;
      end else begin
        leading = 1'b0;
      end
    end
  end
`else
  assign dark = disp_q.blank;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      idx    <= '0;
      pend_q <= '0;
      disp_q <= '0;
      an_q   <= '1;
      seg_q  <= 7'h7F;
      dp_q   <= 1'b1;
      tick_q <= 1'b0;
    end else begin
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      if (cnt == CNT_LAST) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
      if (bus.wr_en) begin
        pend_q <= wr_frame;
      end
      // A write landing on the swap cycle goes straight to the display.
      if (swap) begin
        disp_q <= bus.wr_en ? wr_frame : pend_q;
      end
      tick_q <= swap;
      // First cycle of each slot is dark so the previous digit cannot ghost.
      if (cnt == '0) begin
        an_q  <= '1;
        seg_q <= 7'h7F;
        dp_q  <= 1'b1;
      end else begin
        an_q  <= ~(NUM_DIGITS'(1) << idx);
        seg_q <= dark[idx] ? 7'h7F : enc_seg;
        dp_q  <= dark[idx] | ~disp_q.dp[idx];
      end
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.an         = an_q;
  assign bus.frame_tick = tick_q;

endmodule
